// File: rtl/mem_stage_lsu_pkg.sv
// lsu_pkg: shared types and lane widths for the MEM-stage load/store unit
package lsu_pkg;
    typedef enum logic [1:0] {SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10} size_e;
    typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR, ST_RESP} state_e;
    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;
    localparam int WORD_W = 32;
endpackage

// File: rtl/mem_stage_lsu_if.sv
// mem_stage_lsu_if: word-addressed data-memory bus, LSU is master, memory is slave
interface mem_stage_lsu_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic read;
    logic write;
    modport master(output addr, read, write, wdata, input rdata);
    modport slave(input addr, read, write, wdata, output rdata);
endinterface

// File: rtl/mem_stage_lsu_align.sv
// lsu_align: little-endian lane extract/extend for loads and lane merge for stores
module lsu_align
    import lsu_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    input  logic [1:0]        lane,
    input  logic [1:0]        size,
    input  logic              sgn,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] load_data,
    output logic [WORD_W-1:0] merge_data
);
    logic [BYTE_W-1:0] b;
    logic [HALF_W-1:0] h;
    logic [WORD_W-1:0] mask;
    logic [WORD_W-1:0] ins;
    always_comb begin
        b = word[{lane, 3'b000} +: BYTE_W];
        h = word[{lane[1], 4'b0000} +: HALF_W];
        load_data = size == SZ_B ? {{(WORD_W-BYTE_W){sgn & b[BYTE_W-1]}}, b}
                  : size == SZ_H ? {{(WORD_W-HALF_W){sgn & h[HALF_W-1]}}, h}
                  : word;
        // replicate the store data into every lane, then keep only the addressed one
        mask = size == SZ_B ? 32'h0000_00FF << {lane, 3'b000}
             : size == SZ_H ? 32'h0000_FFFF << {lane[1], 4'b0000}
             : '1;
        ins = size == SZ_B ? {4{wdata[BYTE_W-1:0]}}
            : size == SZ_H ? {2{wdata[HALF_W-1:0]}}
            : wdata;
        merge_data = (word & ~mask) | (ins & mask);
    end
endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit driving a fixed-latency word memory, RMW for sub-word stores
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int MEM_LAT = 2,
    parameter int DEPTH   = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        stall,
    mem_stage_lsu_if.master mem
);
    localparam int CW = $clog2(MEM_LAT + 1);
    localparam logic [CW-1:0] LAT = CW'(MEM_LAT);
    state_e      state;
    logic [CW-1:0] cnt;
    logic [1:0]  lane;
    logic [1:0]  size;
    logic        sgn;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] load_data;
    logic [31:0] merge_data;
    logic        err;
    logic        last;
    assign req_ready = state == ST_IDLE;
    assign stall = !req_ready;
    assign last = cnt == CW'(1);
    assign err = req_size == 2'b11
              || (req_size == SZ_H && req_addr[0])
              || (req_size == SZ_W && req_addr[1:0] != 2'b00)
              || req_addr[31:2] >= 30'(DEPTH);
    lsu_align u_align (
        .word(mem.rdata),
        .lane(lane),
        .size(size),
        .sgn(sgn),
        .wdata(wdata),
        .load_data(load_data),
        .merge_data(merge_data)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt <= '0;
            lane <= '0;
            size <= '0;
            sgn <= 1'b0;
            we <= 1'b0;
            wdata <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err <= 1'b0;
            mem.addr <= '0;
            mem.read <= 1'b0;
            mem.write <= 1'b0;
            mem.wdata <= '0;
        end else begin
            case (state)
                ST_IDLE: if (req_valid) begin
                    lane <= req_addr[1:0];
                    size <= req_size;
                    sgn <= req_signed;
                    we <= req_we;
                    wdata <= req_wdata;
                    mem.addr <= {2'b00, req_addr[31:2]};
                    cnt <= LAT;
                    if (err) begin
                        state <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_err <= 1'b1;
                    end else if (req_we && req_size == SZ_W) begin
                        state <= ST_WR;
                        mem.write <= 1'b1;
                        mem.wdata <= req_wdata;
                    end else begin
                        state <= ST_RD;
                        mem.read <= 1'b1;
                    end
                end
                // a store reaching RD is always sub-word, so the read feeds the merge
                ST_RD: if (last) begin
                    mem.read <= 1'b0;
                    if (we) begin
                        state <= ST_WR;
                        mem.write <= 1'b1;
                        mem.wdata <= merge_data;
                        cnt <= LAT;
                    end else begin
                        state <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= load_data;
                    end
                end else cnt <= cnt - 1'b1;
                ST_WR: if (last) begin
                    mem.write <= 1'b0;
                    state <= ST_RESP;
                    resp_valid <= 1'b1;
                end else cnt <= cnt - 1'b1;
                default: begin
                    state <= ST_IDLE;
                    resp_valid <= 1'b0;
                    resp_err <= 1'b0;
                    resp_rdata <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed checks of mem_stage_lsu against a 10-word memory, MEM_LAT=2
module tb_mem_stage_lsu;
    import lsu_pkg::*;
    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        stall;
    logic [31:0] ram [10];
    logic        both = 1'b0;
    int          ncmp = 0;
    int          nfail = 0;
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          nrd;
    int          nwr;
    int          nresp;

    mem_stage_lsu_if bus ();

    mem_stage_lsu #(.MEM_LAT(2), .DEPTH(10)) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we(req_we),
        .req_size(req_size),
        .req_signed(req_signed),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .stall(stall),
        .mem(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.rdata = bus.addr < 32'd10 ? ram[bus.addr[3:0]] : 32'hDEAD_BEEF;
    always @(posedge clk) if (bus.write && bus.addr < 32'd10) ram[bus.addr[3:0]] <= bus.wdata;
    always @(negedge clk) if (bus.read && bus.write) both <= 1'b1;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic txn(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd);
        req_we = we;
        req_size = sz;
        req_signed = sg;
        req_addr = a;
        req_wdata = wd;
        req_valid = 1'b1;
        cyc();
        req_valid = 1'b0;
        lat = 1;
        nrd = 0;
        nwr = 0;
        while (!resp_valid && lat < 20) begin
            nrd += int'(bus.read);
            nwr += int'(bus.write);
            cyc();
            lat++;
        end
        rd = resp_rdata;
        er = resp_err;
        cyc();
    endtask

    initial begin
        ram = '{32'd4, 32'd2, 32'd3, 32'd5, 32'd7, 32'd8, 32'd9, 32'd0, 32'd1, 32'd4};
        reset = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_size = 2'b00;
        req_signed = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        #1;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_strobes", {30'd0, bus.read, bus.write}, 32'd0);
        chk("rst_mem_addr", bus.addr, 32'd0);
        chk("rst_mem_wdata", bus.wdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        cyc();

        // word load at 0x4, cycle by cycle
        req_we = 1'b0; req_size = SZ_W; req_signed = 1'b0; req_addr = 32'h4; req_valid = 1'b1;
        cyc();
        req_valid = 1'b0;
        chk("ldw_t1_read", 32'(bus.read), 32'd1);
        chk("ldw_t1_write", 32'(bus.write), 32'd0);
        chk("ldw_t1_addr", bus.addr, 32'd1);
        chk("ldw_t1_stall", 32'(stall), 32'd1);
        chk("ldw_t1_ready", 32'(req_ready), 32'd0);
        cyc();
        chk("ldw_t2_read", 32'(bus.read), 32'd1);
        chk("ldw_t2_valid", 32'(resp_valid), 32'd0);
        cyc();
        chk("ldw_t3_read", 32'(bus.read), 32'd0);
        chk("ldw_t3_valid", 32'(resp_valid), 32'd1);
        chk("ldw_t3_rdata", resp_rdata, 32'h0000_0002);
        chk("ldw_t3_err", 32'(resp_err), 32'd0);
        cyc();
        chk("ldw_t4_valid", 32'(resp_valid), 32'd0);
        chk("ldw_t4_ready", 32'(req_ready), 32'd1);

        // byte store 0xAB at 0x9: RD, RD, WR, WR, RESP
        req_we = 1'b1; req_size = SZ_B; req_addr = 32'h9; req_wdata = 32'h0000_00AB; req_valid = 1'b1;
        cyc();
        req_valid = 1'b0;
        chk("stb_t1_read", 32'(bus.read), 32'd1);
        chk("stb_t1_addr", bus.addr, 32'd2);
        cyc();
        chk("stb_t2_read", 32'(bus.read), 32'd1);
        cyc();
        chk("stb_t3_strobes", {30'd0, bus.read, bus.write}, 32'd1);
        chk("stb_t3_wdata", bus.wdata, 32'h0000_AB03);
        chk("stb_t3_addr", bus.addr, 32'd2);
        cyc();
        chk("stb_t4_write", 32'(bus.write), 32'd1);
        chk("stb_t4_valid", 32'(resp_valid), 32'd0);
        cyc();
        chk("stb_t5_write", 32'(bus.write), 32'd0);
        chk("stb_t5_valid", 32'(resp_valid), 32'd1);
        chk("stb_t5_rdata", resp_rdata, 32'd0);
        chk("stb_t5_err", 32'(resp_err), 32'd0);
        cyc();
        chk("stb_ram2", ram[2], 32'h0000_AB03);

        // word store then extending loads of the same word
        txn(1'b1, SZ_W, 1'b0, 32'h1C, 32'hFFFF_FF80);
        chk("stw_lat", 32'(lat), 32'd3);
        chk("stw_nwr", 32'(nwr), 32'd2);
        chk("stw_nrd", 32'(nrd), 32'd0);
        chk("stw_ram7", ram[7], 32'hFFFF_FF80);
        txn(1'b0, SZ_B, 1'b1, 32'h1C, 32'd0);
        chk("lbs_rdata", rd, 32'hFFFF_FF80);
        chk("lbs_lat", 32'(lat), 32'd3);
        txn(1'b0, SZ_B, 1'b0, 32'h1C, 32'd0);
        chk("lbu_rdata", rd, 32'h0000_0080);
        txn(1'b0, SZ_H, 1'b1, 32'h1C, 32'd0);
        chk("lhs_rdata", rd, 32'hFFFF_FF80);
        txn(1'b0, SZ_B, 1'b1, 32'h1D, 32'd0);
        chk("lbs_lane1", rd, 32'hFFFF_FFFF);
        txn(1'b1, SZ_H, 1'b0, 32'h1E, 32'hCAFE_1234);
        chk("sth_lat", 32'(lat), 32'd5);
        chk("sth_nrd", 32'(nrd), 32'd2);
        chk("sth_nwr", 32'(nwr), 32'd2);
        chk("sth_ram7", ram[7], 32'h1234_FF80);
        txn(1'b0, SZ_H, 1'b0, 32'h1E, 32'd0);
        chk("lhu_upper", rd, 32'h0000_1234);
        txn(1'b0, SZ_B, 1'b1, 32'h1F, 32'd0);
        chk("lbs_lane3", rd, 32'h0000_0012);
        txn(1'b0, SZ_W, 1'b0, 32'h24, 32'd0);
        chk("ldw_last_word", rd, 32'h0000_0004);
        chk("ldw_last_err", 32'(er), 32'd0);

        // error cases: response next cycle, no strobes
        txn(1'b0, SZ_W, 1'b0, 32'h6, 32'd0);
        chk("mis_err", 32'(er), 32'd1);
        chk("mis_lat", 32'(lat), 32'd1);
        chk("mis_rdata", rd, 32'd0);
        txn(1'b0, SZ_W, 1'b0, 32'h28, 32'd0);
        chk("oor_err", 32'(er), 32'd1);
        chk("oor_lat", 32'(lat), 32'd1);
        txn(1'b1, SZ_H, 1'b0, 32'h1, 32'h1111);
        chk("mish_err", 32'(er), 32'd1);
        txn(1'b0, 2'b11, 1'b0, 32'h0, 32'd0);
        chk("badsz_err", 32'(er), 32'd1);
        chk("badsz_strobes", 32'(nrd + nwr), 32'd0);
        chk("sth_ram0_intact", ram[0], 32'd4);

        // reset during the second RD cycle of a byte store
        req_we = 1'b1; req_size = SZ_B; req_addr = 32'h8; req_wdata = 32'h55; req_valid = 1'b1;
        cyc();
        req_valid = 1'b0;
        chk("rrst_t1_read", 32'(bus.read), 32'd1);
        cyc();
        chk("rrst_t2_read", 32'(bus.read), 32'd1);
        reset = 1'b1;
        #1;
        chk("rrst_strobes", {30'd0, bus.read, bus.write}, 32'd0);
        chk("rrst_ready", 32'(req_ready), 32'd1);
        chk("rrst_stall", 32'(stall), 32'd0);
        chk("rrst_addr", bus.addr, 32'd0);
        nresp = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            nresp += int'(resp_valid) + int'(bus.write);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            nresp += int'(resp_valid) + int'(bus.write);
        end
        chk("rrst_no_resp_or_write", 32'(nresp), 32'd0);
        chk("rrst_ram2", ram[2], 32'h0000_AB03);

        // back-to-back word loads with req_valid held; address change while busy is ignored
        req_we = 1'b0; req_size = SZ_W; req_signed = 1'b0; req_addr = 32'h0; req_valid = 1'b1;
        cyc();
        req_addr = 32'h10;
        chk("b2b_t1_stall", 32'(stall), 32'd1);
        cyc();
        chk("b2b_t2_stall", 32'(stall), 32'd1);
        cyc();
        chk("b2b_t3_valid", 32'(resp_valid), 32'd1);
        chk("b2b_t3_rdata", resp_rdata, 32'd4);
        chk("b2b_t3_stall", 32'(stall), 32'd1);
        chk("b2b_t3_ready", 32'(req_ready), 32'd0);
        cyc();
        chk("b2b_t4_ready", 32'(req_ready), 32'd1);
        chk("b2b_t4_stall", 32'(stall), 32'd0);
        chk("b2b_t4_read", 32'(bus.read), 32'd0);
        cyc();
        req_valid = 1'b0;
        chk("b2b_t5_read", 32'(bus.read), 32'd1);
        chk("b2b_t5_addr", bus.addr, 32'd4);
        chk("b2b_t5_stall", 32'(stall), 32'd1);
        cyc();
        chk("b2b_t6_stall", 32'(stall), 32'd1);
        cyc();
        chk("b2b_t7_valid", 32'(resp_valid), 32'd1);
        chk("b2b_t7_rdata", resp_rdata, 32'd7);
        cyc();
        chk("b2b_t8_ready", 32'(req_ready), 32'd1);
        chk("never_rd_and_wr", 32'(both), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Load/store unit for the MEM stage of the pipelined core. It is the initiator side of the data-memory interface. It takes one load or store request per transaction from the EX/MEM register and drives the word-addressed data memory's read/write strobes, holding each strobe for the memory's fixed access latency. Byte and halfword stores are done as read-modify-write. Loads are lane-extracted and sign- or zero-extended. The block stalls the pipeline while busy.

## Interface
Parameters:
- `MEM_LAT`, default 2: cycles each strobe is held; must be ≥1.
- `DEPTH`, default 10: number of 32-bit words in data memory.

Ports:
- `clk` in 1: rising-edge clock.
- `reset` in 1: reset, asynchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word; 11 is illegal and reports an error.
- `req_signed` in 1: sign-extend load data.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `resp_err` out 1: misaligned, out-of-range or illegal size; valid with `resp_valid`.
- `stall` out 1: high whenever state ≠ IDLE.
- `mem_addr` out 32: word index, `req_addr >> 2`.
- `mem_read` out 1: read strobe.
- `mem_write` out 1: write strobe.
- `mem_wdata` out 32: word to write.
- `mem_rdata` in 32: word read.

## Operation
- States are IDLE, RD, WR and RESP.
- A request is accepted on a rising edge with `req_valid` high and state IDLE. Address, size, signed, we and wdata are latched at that edge.
- Error check happens at accept:
  - half with `addr[0]`≠0, or word with `addr[1:0]`≠0;
  - word index ≥ `DEPTH`;
  - size 11.
  - On error: IDLE→RESP with `resp_err`=1 and no memory strobe.
- Load: IDLE→RD. `mem_read` is held for `MEM_LAT` cycles and `mem_rdata` is captured on the last one, then RD→RESP.
- Word store: IDLE→WR. `mem_write` is held for `MEM_LAT` cycles with `mem_wdata`=`req_wdata`, then WR→RESP.
- Byte/half store: IDLE→RD (read the old word), then RD→WR writing the merged word, then WR→RESP.
- Lanes are little-endian:
  - byte lane = `addr[1:0]`;
  - half lane = `addr[1]`;
  - merge replaces only the addressed lane with the low bits of `req_wdata`.
- Load extension:
  - byte: bit 7 when `req_signed`, else zero-fill;
  - half: bit 15 when `req_signed`, else zero-fill;
  - word: unchanged.
- RESP lasts exactly 1 cycle, then returns to IDLE. No request is accepted in RESP.
- `mem_read` and `mem_write` are never high together. `mem_addr` is stable for the whole transaction.

## Timing
- Reset values: state IDLE, `req_ready`=1, `stall`=0, `resp_valid`=0, `resp_err`=0, `resp_rdata`=0, `mem_read`=0, `mem_write`=0, `mem_addr`=0, `mem_wdata`=0.
- With accept at edge T, the strobe is high during cycles T+1…T+`MEM_LAT`.
- Latency from accept to `resp_valid`:
  - load or word store: `resp_valid` in cycle T+`MEM_LAT`+1;
  - partial store: T+2·`MEM_LAT`+1;
  - error: T+1.
- Throughput: the next accept is possible at the edge ending RESP + 1, i.e. the first IDLE cycle.
- The latency counter is `$clog2(MEM_LAT+1)` bits wide, loaded at strobe start and decremented each cycle.
- Reset mid-transaction (any state): all outputs return to their reset values immediately (asynchronously). No response is issued. A partial RMW write that has not started is never issued.
- `req_valid` while busy is ignored; the requester holds it until `req_ready`.

## Structure
- `lsu_pkg` holds:
  - the size enum (`SZ_B`, `SZ_H`, `SZ_W`);
  - the state enum;
  - the lane-width constants.
- Sub-module `lsu_align` is purely combinational and does lane extract + extend for loads and lane merge for stores. The FSM, counter and latches stay in the top module.

## Test plan
- Memory preloaded 4,2,3,5,7,8,9,0,1,4 with `MEM_LAT`=2. Load word at addr 0x4 → `mem_read` high 2 cycles, `resp_rdata`=0x00000002 at T+3, `resp_err`=0.
- Store byte 0xAB at addr 0x9 → RD 2 cycles, then WR with `mem_wdata`=0x0000AB03 at word 2, `resp_valid` at T+5.
- Store word 0xFFFFFF80 at 0x1C, then signed byte load at 0x1C → 0xFFFFFF80; unsigned → 0x00000080; signed half → 0xFFFFFF80.
- Misaligned word load at 0x6, and word load at 0x28 (index 10) → `resp_err`=1 at T+1, no strobe ever asserted.
- Assert `reset` during the second RD cycle of a byte store → strobes drop in the same cycle, word unchanged, no `resp_valid`, `req_ready`=1.
- Back-to-back word loads with `req_valid` held high → second accept in the cycle after RESP, `stall` high throughout each transaction.
